// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data bus: stores to TX_DATA
// fill a TX FIFO that a baud-divided serializer drains onto the tx pin.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic        w_enable,
    input  logic [1:0]  access_size,
    input  logic        RdUn,
    output logic [31:0] data_out,
    output logic        sel,
    output logic        tx
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] SIZE_WORD   = 2'b10;
    localparam logic [3:0] OFF_TX_DATA = 4'h0;
    localparam logic [3:0] OFF_STATUS  = 4'h4;
    localparam logic [3:0] OFF_BAUD    = 4'h8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [15:0]      baud_div;
    logic [15:0]      div_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;

    logic        wr;
    logic        push;
    logic        push_ok;
    logic        pop;
    logic        full;
    logic        empty;
    logic        busy;
    logic        bit_end;
    logic        clr_ovf;
    logic        baud_wr;
    logic [31:0] status;
    logic        unused_ok;

    // Bus decode: everything is combinational on the current bus cycle.
    assign sel     = (address[31:4] == BASE_ADDR[31:4]);
    assign wr      = sel & w_enable;
    assign push    = wr && (address[3:0] == OFF_TX_DATA);
    assign clr_ovf = wr && (address[3:0] == OFF_STATUS) && data_in[3];
    assign baud_wr = wr && (address[3:0] == OFF_BAUD) && (access_size == SIZE_WORD);

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign busy    = (state != IDLE);

    // Reads are always zero-extended, so the signedness hint is not needed.
    assign unused_ok = ^{RdUn, data_in[31:16]};

    always_comb begin
        status      = '0;
        status[0]   = busy;
        status[1]   = full;
        status[2]   = empty;
        status[3]   = overflow;
        status[8:4] = 5'(count);
    end

    always_comb begin
        data_out = '0;
        if (sel) begin
            case (address[3:0])
                OFF_STATUS: data_out = status;
                OFF_BAUD:   data_out = {16'h0000, baud_div};
                default:    data_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baud_div <= DEFAULT_DIV;
        end else if (baud_wr) begin
            baud_div <= data_in[15:0];
        end
    end

    // FIFO storage carries no reset; only pointers, count and flags do.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // >= rather than == so a divisor lowered mid-bit cannot run the counter
    // through a full 16-bit wrap.
    assign bit_end = (div_cnt >= baud_div);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_cnt == 3'd7)) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (pop) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (state != IDLE) begin
            if (bit_end) begin
                div_cnt <= '0;
                if (state == DATA) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            shift <= mem[rd_ptr];
        end else if ((state == DATA) && bit_end) begin
            shift <= {1'b0, shift[7:1]};
        end
    end

    always_comb begin
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = shift[0];
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed bus stores/loads plus a serial-line monitor
// that decodes 8N1 frames and scores them against a queue of expected bytes.
module tb_mmio_uart_tx;
    localparam logic [31:0] A_TX   = 32'h0200_0000;
    localparam logic [31:0] A_STAT = 32'h0200_0004;
    localparam logic [31:0] A_BAUD = 32'h0200_0008;
    localparam logic [1:0]  SZ_B   = 2'b00;
    localparam logic [1:0]  SZ_H   = 2'b01;
    localparam logic [1:0]  SZ_W   = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] data_in = '0;
    logic        w_enable = 1'b0;
    logic [1:0]  access_size = SZ_W;
    logic        RdUn = 1'b0;
    logic [31:0] data_out;
    logic        sel;
    logic        tx;

    int          passed = 0;
    int          total = 0;
    int          cur_div = 3;
    logic [7:0]  exp_q[$];

    mmio_uart_tx #(
        .BASE_ADDR  (32'h0200_0000),
        .FIFO_DEPTH (8),
        .DEFAULT_DIV(16'd3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address),
        .data_in    (data_in),
        .w_enable   (w_enable),
        .access_size(access_size),
        .RdUn       (RdUn),
        .data_out   (data_out),
        .sel        (sel),
        .tx         (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        address     = a;
        data_in     = d;
        access_size = sz;
        w_enable    = 1'b1;
        @(posedge clk);
        #1;
        w_enable = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        address  = a;
        w_enable = 1'b0;
        #1;
        check(name, data_out, exp);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n        = 0;
        address  = A_STAT;
        w_enable = 1'b0;
        #1;
        while (data_out !== 32'h4 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, data_out, 32'h4);
    endtask

    // Serial monitor: detects a falling edge, samples each bit on its first
    // clock, and discards frames cut short by reset.
    initial begin : monitor
        logic       prev;
        logic [7:0] b;
        logic       stop_bit;
        logic       ok;
        int         d;
        logic [7:0] e;
        prev     = 1'b1;
        b        = '0;
        stop_bit = 1'b1;
        wait (rst_n === 1'b1);
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev = 1'b1;
            end else if (prev === 1'b1 && tx === 1'b0) begin
                ok = 1'b1;
                d  = cur_div;
                for (int k = 0; k < 9 && ok; k++) begin
                    for (int c = 0; c <= d && ok; c++) begin
                        @(negedge clk);
                        if (rst_n !== 1'b1) ok = 1'b0;
                    end
                    if (ok) begin
                        if (k < 8) b[k] = tx;
                        else stop_bit = tx;
                    end
                end
                prev = ok ? stop_bit : 1'b1;
                if (ok) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", {24'h0, b}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_byte", {24'h0, b}, {24'h0, e});
                        check("stop_bit", {31'h0, stop_bit}, 32'h1);
                    end
                end
            end else begin
                prev = tx;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin : stimulus
        logic [19:0] got;
        logic [19:0] exp_vec;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        read_check("reset_status", A_STAT, 32'h4);
        check("reset_tx", {31'h0, tx}, 32'h1);
        read_check("reset_baud", A_BAUD, 32'h3);
        read_check("txdata_reads_zero", A_TX, 32'h0);
        check("sel_in_window", {31'h0, sel}, 32'h1);

        // Single frame 0xA5 at DIV=3
        exp_q.push_back(8'hA5);
        store(A_TX, 32'h0000_00A5, SZ_B);
        @(posedge clk); #1;
        check("a5_start_first", {31'h0, tx}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("a5_start_last", {31'h0, tx}, 32'h0);
        @(posedge clk); #1;
        check("a5_bit0", {31'h0, tx}, 32'h1);
        repeat (35) @(posedge clk);
        #1;
        read_check("a5_busy_at_n40", A_STAT, 32'h5);
        @(posedge clk);
        read_check("a5_idle_at_n41", A_STAT, 32'h4);

        // Nine consecutive stores: head pops at once, so nothing is lost
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(8'(i));
            store(A_TX, 32'(i), SZ_B);
        end
        read_check("nine_no_loss_status", A_STAT, 32'h83);
        wait_idle("nine_drain", 1000);

        // Back-to-back frames at DIV=0
        store(A_BAUD, 32'h0, SZ_W);
        cur_div = 0;
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h5A);
        store(A_TX, 32'hC3, SZ_B);
        store(A_TX, 32'h5A, SZ_B);
        got[0] = tx;
        for (int i = 1; i < 20; i++) begin
            @(posedge clk); #1;
            got[i] = tx;
        end
        exp_vec = {1'b1, 8'h5A, 1'b0, 1'b1, 8'hC3, 1'b0};
        check("b2b_20_clocks", {12'h0, got}, {12'h0, exp_vec});
        wait_idle("b2b_drain", 50);

        // Overflow with the serializer stalled
        store(A_BAUD, 32'h0000_FFFF, SZ_W);
        cur_div = 65535;
        store(A_TX, 32'h55, SZ_B);
        for (int i = 0; i < 9; i++) begin
            store(A_TX, 32'h10 + 32'(i), SZ_B);
        end
        read_check("overflow_status", A_STAT, 32'h8B);
        store(A_STAT, 32'h0, SZ_W);
        read_check("ovf_kept_bit3_zero", A_STAT, 32'h8B);
        store(A_STAT, 32'h8, SZ_W);
        read_check("ovf_cleared", A_STAT, 32'h83);

        // Reset aborts the stalled frame and empties the FIFO
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cur_div = 3;
        check("rst_tx_idle", {31'h0, tx}, 32'h1);
        read_check("rst_status", A_STAT, 32'h4);
        read_check("rst_baud_default", A_BAUD, 32'h3);

        // Reset during DATA bit 4 abandons the frame
        store(A_TX, 32'h3C, SZ_B);
        repeat (22) @(posedge clk);
        #1;
        read_check("mid_frame_busy", A_STAT, 32'h5);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_tx", {31'h0, tx}, 32'h1);
        read_check("mid_rst_status", A_STAT, 32'h4);
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("mid_rst_stays_high", {31'h0, tx}, 32'h1);

        // Out-of-window access, unmapped offset and ignored halfword divisor store
        address     = 32'h0300_0000;
        data_in     = 32'h77;
        access_size = SZ_W;
        w_enable    = 1'b1;
        #1;
        check("out_window_sel", {31'h0, sel}, 32'h0);
        check("out_window_data", data_out, 32'h0);
        @(posedge clk); #1;
        w_enable = 1'b0;
        read_check("out_window_no_push", A_STAT, 32'h4);
        read_check("offset_c_reads_zero", 32'h0200_000C, 32'h0);
        store(A_BAUD, 32'h7, SZ_H);
        read_check("baud_half_ignored", A_BAUD, 32'h3);
        store(A_BAUD, 32'h7, SZ_B);
        read_check("baud_byte_ignored", A_BAUD, 32'h3);
        store(A_BAUD, 32'h1234_0005, SZ_W);
        read_check("baud_word_loads", A_BAUD, 32'h5);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
